// File: rtl/led_seq_ctrl.sv
// Key-driven LED step sequencer: up/down counter advanced by an internal
// clock-enable tick, with wrap/stop modes and bar or running-light LED decode.
module led_seq_ctrl #(
  parameter int TICK_DIV  = 25000000,
  parameter int LED_W     = 18,
  parameter int CNT_W     = 4,
  parameter int MAX_COUNT = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             dir,
  input  logic             wrap,
  input  logic             mode,
  output logic [LED_W-1:0] led,
  output logic [CNT_W-1:0] count,
  output logic [2:0]       state,
  output logic             tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_DONE  = 3'd3
  } state_t;

  state_t             state_r, state_n;
  logic [DIV_W-1:0]   div_r;
  logic [LED_W-1:0]   ring_r;
  logic               start_q, pause_q;
  logic               start_rise_r, pause_rise_r;
  logic               load, do_step, div_end, at_term;
  logic [LED_W-1:0]   led_bar;

  assign state   = state_r;
  assign div_end = (div_r == DIV_LAST);
  assign at_term = dir ? (count == '0) : (count == CNT_MAX);

  // Key edges are registered, giving two cycles from key edge to state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q      <= start;
      pause_q      <= pause;
      start_rise_r <= 1'b0;
      pause_rise_r <= 1'b0;
    end else begin
      start_q      <= start;
      pause_q      <= pause;
      start_rise_r <= start & ~start_q;
      pause_rise_r <= pause & ~pause_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    load    = 1'b0;
    do_step = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start_rise_r) begin
          state_n = S_RUN;
          load    = 1'b1;
        end
      end
      S_RUN: begin
        if (pause_rise_r) begin
          state_n = S_PAUSE;
        end else if (div_end) begin
          do_step = 1'b1;
          if (at_term && !wrap) state_n = S_DONE;
        end
      end
      S_PAUSE: begin
        if (pause_rise_r || start_rise_r) state_n = S_RUN;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      div_r  <= '0;
      tick   <= 1'b0;
      ring_r <= '0;
    end else begin
      tick <= 1'b0;
      if (load) begin
        div_r  <= '0;
        count  <= dir ? CNT_MAX : '0;
        ring_r <= dir ? {1'b1, {(LED_W-1){1'b0}}} : {{(LED_W-1){1'b0}}, 1'b1};
      end else if (state_r == S_RUN && !pause_rise_r) begin
        if (div_end) begin
          div_r <= '0;
          tick  <= 1'b1;
        end else begin
          div_r <= div_r + 1'b1;
        end
        // A terminal step without wrap leaves count and ring untouched.
        if (do_step && (!at_term || wrap)) begin
          if (!dir) begin
            count  <= at_term ? '0 : count + 1'b1;
            ring_r <= {ring_r[LED_W-2:0], ring_r[LED_W-1]};
          end else begin
            count  <= at_term ? CNT_MAX : count - 1'b1;
            ring_r <= {ring_r[0], ring_r[LED_W-1:1]};
          end
        end
      end
    end
  end

  always_comb begin
    led_bar = '0;
    for (int unsigned i = 0; i < LED_W; i++) begin
      led_bar[i] = (i < 32'(count));
    end
  end

  always_comb begin
    case (state_r)
      S_IDLE:  led = '0;
      S_DONE:  led = '1;
      default: led = mode ? ring_r : led_bar;
    endcase
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed self-checking bench for led_seq_ctrl with a short tick period.
module tb_led_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, pause, dir, wrap, mode;
  logic [7:0] led;
  logic [3:0] count;
  logic [2:0] state;
  logic       tick;

  int n_checks = 0;
  int n_fail   = 0;
  int n;

  led_seq_ctrl #(
    .TICK_DIV (4),
    .LED_W    (8),
    .CNT_W    (4),
    .MAX_COUNT(5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .pause(pause),
    .dir  (dir),
    .wrap (wrap),
    .mode (mode),
    .led  (led),
    .count(count),
    .state(state),
    .tick (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Returns the number of cycles until tick is seen (64 on timeout).
  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!tick && cycles < 64);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
  endtask

  logic [3:0] up_cnt [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1};
  logic [7:0] up_led [7] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h00, 8'h01};
  logic [3:0] dn_cnt [6] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd5};
  logic [7:0] dn_led [6] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0;
    dir = 1'b0; wrap = 1'b1; mode = 1'b0;
    cyc(2);
    reset = 1'b0;
    check("rst_state", state, 0);
    check("rst_count", count, 0);
    check("rst_led",   led,   8'h00);
    check("rst_tick",  tick,  0);

    // Up, wrap, bar LEDs
    start_pulse();
    check("up_state", state, 1);
    check("up_load_count", count, 0);
    for (int i = 0; i < 7; i++) begin
      wait_tick(n);
      check("up_period", n, 4);
      check("up_count", count, up_cnt[i]);
      check("up_led", led, up_led[i]);
    end
    cyc(1);
    check("tick_one_cycle", tick, 0);

    // Up, stop at terminal
    wrap = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      wait_tick(n);
      check("stop_count", count, i);
    end
    wait_tick(n);
    check("done_state", state, 3);
    check("done_count", count, 5);
    check("done_led", led, 8'hFF);
    cyc(3);
    check("done_hold", state, 3);
    start_pulse();
    check("restart_state", state, 1);
    check("restart_count", count, 0);

    // Down, wrap, running light
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    dir = 1'b1; wrap = 1'b1; mode = 1'b1;
    start_pulse();
    check("dn_state", state, 1);
    check("dn_load_count", count, 5);
    check("dn_load_ring", led, 8'h80);
    for (int i = 0; i < 6; i++) begin
      wait_tick(n);
      check("dn_period", n, 4);
      check("dn_count", count, dn_cnt[i]);
      check("dn_ring", led, dn_led[i]);
    end
    mode = 1'b0;
    #1 check("mode_bar_now", led, 8'h1F);
    mode = 1'b1;
    #1 check("mode_ring_now", led, 8'h02);

    // Pause lands on the divider's last count
    cyc(2);
    pause = 1'b1;
    cyc(1);
    check("pre_pause_state", state, 1);
    cyc(1);
    check("pause_state", state, 2);
    check("pause_count", count, 5);
    check("pause_no_tick", tick, 0);
    pause = 1'b0;
    cyc(3);
    check("pause_hold_count", count, 5);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    cyc(1);
    check("resume_state", state, 1);
    wait_tick(n);
    check("resume_first_tick", n, 1);
    check("resume_count", count, 4);
    check("resume_ring", led, 8'h01);

    // Simultaneous pause and start while paused
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    cyc(1);
    check("pause2_state", state, 2);
    pause = 1'b1; start = 1'b1;
    cyc(1);
    pause = 1'b0; start = 1'b0;
    cyc(1);
    check("dual_resume_state", state, 1);
    cyc(3);
    check("dual_resume_stays", state, 1);

    // Start held through reset
    start = 1'b1; reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(2);
    check("held_start_state", state, 0);
    start = 1'b0;
    cyc(3);
    check("held_release_state", state, 0);

    // Reset mid-run
    dir = 1'b0; wrap = 1'b1; mode = 1'b0;
    start_pulse();
    for (int i = 0; i < 3; i++) wait_tick(n);
    check("mid_count", count, 3);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("mid_rst_state", state, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_led", led, 8'h00);
    check("mid_rst_tick", tick, 0);
    start_pulse();
    wait_tick(n);
    check("mid_restart_period", n, 4);
    check("mid_restart_count", count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
